updown_counter_mod: RTL and testbench
=====================================

# updown_counter_mod

Parametrised up/down modulo counter with synchronous load, wrap or saturate terminal behaviour, and a registered terminal-count pulse. It is the general-purpose successor to the lab's basic up/down counter. It is intended for timebases, address sequencing and display-drive pacing in the same lab designs. An optional compile-time prescaler slows the step rate without external gating.

## Interface
Parameters:
- WIDTH, 8, width of count, limit and load_val.
- PRESCALE_W, 4, width of the prescale divisor (used only with COUNTER_PRESCALE_EN).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- en  input  1  count enable; a step may occur only while high.
- dir  input  1  1 = count up, 0 = count down.
- sat  input  1  0 = wrap at terminal, 1 = saturate (hold) at terminal.
- limit  input  WIDTH  modulo maximum; legal range is 0..limit.
- load  input  1  synchronous load strobe.
- load_val  input  WIDTH  value written on load.
- div  input  PRESCALE_W  prescale divisor; the step rate is 1 per div+1 enabled cycles. Ignored without the macro.
- count  output  WIDTH  current count (registered).
- tc  output  1  terminal-count pulse (registered, one cycle).
- zero  output  1  count == 0 (combinational from the count register).

## Operation
- Priority per edge: rst > load > step > hold.
- rst: count = 0, tc = 0, prescaler = 0.
- load: count = load_val (not clamped to limit), tc = 0, prescaler = 0. load is honoured regardless of en.
- Step: occurs on an edge where en = 1, load = 0 and the prescaler reports a tick. Without the macro, every such edge ticks.
- Up step:
  - count < limit: count + 1.
  - count == limit: wrap mode gives 0; sat mode holds.
- Down step:
  - count > 0 and count <= limit: count − 1.
  - count == 0: wrap mode gives limit; sat mode holds.
- Out of range: when a step occurs with count > limit, count = limit in both modes and directions, and tc is not asserted.
- Terminal value: limit when dir = 1, 0 when dir = 0.
- tc: 1 in the cycle after any step taken from the terminal value, in both modes. In sat mode, tc fires on every step attempted while held at the terminal. Otherwise tc = 0.
- limit = 0: up and down steps from 0 keep count at 0, and every step pulses tc.
- dir, sat and limit may change any cycle. The new values are used on the next step. Already-stored state is not altered.
- Arithmetic is modulo 2^WIDTH internally. No intermediate result is wider than WIDTH, because comparisons against limit/0 precede the add/subtract.

## Timing
- Latency: count reflects a load or step one edge after the qualifying inputs. tc appears in the same cycle as the resulting count.
- zero follows count with no extra cycle.
- Reset values: count = 0, tc = 0, zero = 1.
- Reset mid-count, or mid-prescale: state returns fully to reset values on that edge. A pending tick is discarded.
- Load coincident with en/tick: the load wins and the step is lost.
- en low freezes both count and prescaler; tc drops to 0 on the next edge.

## Configuration
- COUNTER_PRESCALE_EN defined:
  - A PRESCALE_W-bit prescaler increments on each edge with en = 1 and load = 0.
  - When prescaler == div, a tick is issued and the prescaler clears.
  - div = 0 gives a step every enabled cycle.
  - If div is lowered below the current prescaler value, the prescaler continues incrementing and wraps modulo 2^PRESCALE_W before the next tick.
- COUNTER_PRESCALE_EN undefined: no prescaler register exists, every enabled cycle is a tick, and div is unconnected internally.

## Test plan
All scenarios use WIDTH = 4.
- Reset then wrap up: rst for 2 cycles, then en = 1, dir = 1, sat = 0, limit = 9 for 12 cycles -> count 0,1..9,0,1. tc is high only alongside the count = 0 that follows 9. zero = 1 after reset.
- Wrap down and saturate: load_val = 2, then dir = 0. With sat = 0, count goes 2,1,0,9 and tc accompanies the 9. Repeat with sat = 1: count goes 2,1,0,0,0 and tc is high in each cycle after a step from 0.
- Out of range and priority: load_val = 13 with limit = 9 -> count = 13. The next up step gives 9 with tc = 0. Asserting load with load_val = 5 during en = 1 -> count = 5, with no step.
- Reset mid-run: while counting at 6, assert rst with load = 1 -> count = 0 and tc = 0 next edge. en toggling low holds count and zero.
- With COUNTER_PRESCALE_EN and div = 3: en high for 12 cycles from 0 -> count steps to 1, 2, 3, on every 4th enabled edge. Dropping en for 2 cycles mid-period delays the next step by exactly 2 cycles.
- limit = 0 edge case: en = 1, dir = 1, sat = 0 -> count stays 0 and tc = 1 every cycle after the first step.

Source files
------------

// File: rtl/updown_counter_mod.sv
// updown_counter_mod: parametrised up/down modulo counter (0..limit) with
// synchronous load, wrap/saturate terminal behaviour and registered tc pulse.
// Optional prescaler enabled by defining COUNTER_PRESCALE_EN.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   en            count enable (also gates the prescaler)
//   dir           1 = up, 0 = down
//   sat           0 = wrap at terminal, 1 = hold at terminal
//   limit         modulo maximum
//   load/load_val synchronous load (wins over a step)
//   div           prescale divisor, step every div+1 enabled cycles
//   count         registered count
//   tc            registered terminal-count pulse
//   zero          count == 0
module updown_counter_mod #(
   parameter int WIDTH      = 8,
   parameter int PRESCALE_W = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  dir,
   input  logic                  sat,
   input  logic [WIDTH-1:0]      limit,
   input  logic                  load,
   input  logic [WIDTH-1:0]      load_val,
   input  logic [PRESCALE_W-1:0] div,
   output logic [WIDTH-1:0]      count,
   output logic                  tc,
   output logic                  zero
);

   logic             tick;
   logic             step;
   logic [WIDTH-1:0] count_nxt;
   logic             tc_nxt;

`ifdef COUNTER_PRESCALE_EN
   logic [PRESCALE_W-1:0] pre;

   assign tick = (pre == div);

   // Counts enabled, non-load edges; clears on the tick edge. A div
   // lowered below pre lets pre run on and wrap before it matches.
   always_ff @(posedge clk) begin
      if (rst || load) begin
         pre <= '0;
      end else if (en) begin
         if (tick) pre <= '0;
         else      pre <= pre + 1'b1;
      end
   end
`else
   logic unused_div;

   assign unused_div = ^div;
   assign tick       = 1'b1;
`endif

   assign step = en && !load && tick;

   // Range checks come before the add/subtract so nothing overflows.
   always_comb begin
      count_nxt = count;
      tc_nxt    = 1'b0;
      if (load) begin
         count_nxt = load_val;
      end else if (step) begin
         if (count > limit) begin
            // out of range: snap back to limit, no pulse
            count_nxt = limit;
         end else if (dir) begin
            if (count == limit) begin
               tc_nxt = 1'b1;
               if (!sat) count_nxt = '0;
            end else begin
               count_nxt = count + 1'b1;
            end
         end else begin
            if (count == '0) begin
               tc_nxt = 1'b1;
               if (!sat) count_nxt = limit;
            end else begin
               count_nxt = count - 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
         tc    <= 1'b0;
      end else begin
         count <= count_nxt;
         tc    <= tc_nxt;
      end
   end

   assign zero = (count == '0);

endmodule

// File: tb/tb_updown_counter_mod.sv
// tb_updown_counter_mod: directed literal checks plus randomized stimulus
// compared every cycle against a behavioural model of the counter.
module tb_updown_counter_mod;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic       dir;
   logic       sat;
   logic [3:0] limit;
   logic       load;
   logic [3:0] load_val;
   logic [3:0] div;
   logic [3:0] count;
   logic       tc;
   logic       zero;

   int checks = 0;
   int errors = 0;
   bit chk_on = 1'b0;

   int m_count = 0;
   int m_tc    = 0;
   int m_pre   = 0;

   updown_counter_mod #(.WIDTH(4), .PRESCALE_W(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .dir      (dir),
      .sat      (sat),
      .limit    (limit),
      .load     (load),
      .load_val (load_val),
      .div      (div),
      .count    (count),
      .tc       (tc),
      .zero     (zero)
   );

   always #5 clk = ~clk;

   // Reference model: counter value kept as a plain integer.
   always @(posedge clk) begin
      automatic int c   = m_count;
      automatic int t   = 0;
      automatic int p   = m_pre;
      automatic int lim = limit;
      automatic bit tk  = 1'b1;
`ifdef COUNTER_PRESCALE_EN
      tk = (p == int'(div));
`endif
      if (rst) begin
         c = 0;
         p = 0;
      end else if (load) begin
         c = load_val;
         p = 0;
      end else if (en) begin
         p = tk ? 0 : (p + 1) % 16;
         if (tk) begin
            if (c > lim) begin
               c = lim;
            end else if (c == (dir ? lim : 0)) begin
               t = 1;
               if (!sat) c = dir ? 0 : lim;
            end else begin
               c = dir ? c + 1 : c - 1;
            end
         end
      end
      m_count <= c;
      m_tc    <= t;
      m_pre   <= p;
   end

   always @(negedge clk) begin
      if (chk_on) begin
         checks++;
         if (int'(count) != m_count) begin
            errors++;
            $display("FAIL model_count t=%0t got %0d want %0d",
                     $time, count, m_count);
         end
         checks++;
         if (int'(tc) != m_tc) begin
            errors++;
            $display("FAIL model_tc t=%0t got %0d want %0d",
                     $time, tc, m_tc);
         end
         checks++;
         if (zero !== (m_count == 0)) begin
            errors++;
            $display("FAIL model_zero t=%0t got %0b want %0b",
                     $time, zero, m_count == 0);
         end
      end
   end

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic lit(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got %0d want %0d", name, act, exp);
      end
   endtask

   initial begin
      rst = 1; en = 0; dir = 1; sat = 0; limit = 4'd9;
      load = 0; load_val = 0; div = 0;
      cyc();
      chk_on = 1'b1;
      cyc();
      lit("reset_count", count, 0);
      lit("reset_tc", tc, 0);
      lit("reset_zero", zero, 1);

      // wrap up through 9
      rst = 0; en = 1; dir = 1; sat = 0;
      for (int i = 1; i <= 12; i++) begin
         cyc();
         lit("up_count", count, i % 10);
         lit("up_tc", tc, (i == 10) ? 1 : 0);
      end

      // wrap down
      load = 1; load_val = 2; dir = 0;
      cyc(); lit("ld2_count", count, 2);
      load = 0;
      cyc(); lit("dn_1", count, 1);
      cyc(); lit("dn_0", count, 0); lit("dn_0_zero", zero, 1);
      cyc(); lit("dn_wrap", count, 9); lit("dn_wrap_tc", tc, 1);

      // saturate down
      sat = 1; load = 1;
      cyc(); lit("ld2b", count, 2);
      load = 0;
      cyc(); lit("sd_1", count, 1);
      cyc(); lit("sd_0", count, 0); lit("sd_0_tc", tc, 0);
      cyc(); lit("sd_hold", count, 0); lit("sd_hold_tc", tc, 1);
      cyc(); lit("sd_hold2", count, 0); lit("sd_hold2_tc", tc, 1);

      // out of range and load priority
      sat = 0; dir = 1; load = 1; load_val = 13;
      cyc(); lit("oor_load", count, 13);
      load = 0;
      cyc(); lit("oor_snap", count, 9); lit("oor_tc", tc, 0);
      load = 1; load_val = 5;
      cyc(); lit("ld_wins", count, 5); lit("ld_wins_tc", tc, 0);
      load = 0;
      cyc(); lit("to6", count, 6);

      // reset beats load
      rst = 1; load = 1;
      cyc(); lit("rst_mid", count, 0); lit("rst_mid_tc", tc, 0);
      rst = 0; load = 0; en = 0;
      cyc(); lit("en_lo_hold", count, 0); lit("en_lo_zero", zero, 1);

      // limit = 0
      limit = 0; en = 1; dir = 1;
      for (int i = 0; i < 3; i++) begin
         cyc();
         lit("lim0_count", count, 0);
         lit("lim0_tc", tc, 1);
      end

`ifdef COUNTER_PRESCALE_EN
      rst = 1; limit = 9; div = 3;
      cyc();
      rst = 0;
      for (int i = 1; i <= 12; i++) begin
         cyc();
         lit("pre_count", count, i / 4);
      end
      cyc(); cyc();
      en = 0;
      cyc(); cyc();
      lit("pre_hold", count, 3);
      en = 1;
      cyc(); lit("pre_3rd", count, 3);
      cyc(); lit("pre_4th", count, 4);
      div = 0;
`endif

      // randomized phase
      for (int i = 0; i < 3000; i++) begin
         rst      = ($urandom_range(63) == 0);
         load     = ($urandom_range(9) == 0);
         en       = ($urandom_range(3) != 0);
         dir      = $urandom_range(1);
         sat      = ($urandom_range(3) == 0);
         load_val = 4'($urandom_range(15));
         if ($urandom_range(15) == 0) limit = 4'($urandom_range(15));
         if ($urandom_range(31) == 0) div = 4'($urandom_range(3));
         cyc();
      end

      chk_on = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
